mesh_config_sequencer: RTL
==========================

# mesh_config_sequencer

Parametrised configuration loader for a ROWS x COLS switch mesh. It accepts one column-slice of per-row configuration words per valid/ready beat and drives them onto the mesh west edge with per-row shift enables. It can either shift all rows together or skew row r by r cycles to form a systolic wavefront. After every row has shifted COLS words, it issues a single commit pulse so the mesh swaps shadow configuration into active. It sits between the instruction store and the mesh's west-edge input interfaces.

## Interface
- ROWS, default 4: mesh rows; must be >= 1.
- COLS, default 4: mesh columns, which is also the beats per load; must be >= 1.
- CFG_W, default 64: configuration word width per switch.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load pass; honoured only in IDLE.
- skew  in  1  sampled with start. 0 = all rows aligned; 1 = row r delayed r cycles.
- abort  in  1  synchronous cancel of the current pass.
- cfg_valid  in  1  input beat valid.
- cfg_ready  out  1  input beat ready.
- cfg_data  in  ROWS*CFG_W  beat payload; row r word at [r*CFG_W +: CFG_W].
- cfg_out  out  ROWS*CFG_W  west-edge configuration word per row (registered).
- cfg_shift  out  ROWS  per-row shift enable; mesh shifts row r east when high.
- cfg_commit  out  1  one-cycle pulse that ends the pass.
- busy  out  1  high in every state except IDLE.
- done  out  1  sticky high after commit; cleared by start, abort or reset.
- err  out  1  one-cycle pulse when start arrives while busy.

## Operation
- States: IDLE, FETCH, DRAIN, COMMIT.
- IDLE -> FETCH on start.
  - On this transition, latch skew, clear the beat counter and clear done.
- FETCH:
  - cfg_ready = 1, decoded from state only and independent of cfg_valid.
  - A beat is accepted on an edge where cfg_valid & cfg_ready.
  - Beat k is the configuration for column COLS-1-k, so the first beat travels furthest.
  - Accepting beat COLS-1 moves the block to DRAIN.
- Per-row delay line (depth ROWS-1, with a valid bit per stage):
  - It advances every cycle in FETCH and DRAIN, including stall cycles, which become bubbles.
  - Row 0 is tapped at stage 0; row r is tapped at stage r when skew=1, otherwise also at stage 0.
  - cfg_shift[r] is the valid bit of row r's tap; cfg_out row r is the word at that tap.
  - cfg_out holds its last value when cfg_shift[r]=0.
- DRAIN:
  - cfg_ready = 0.
  - Lasts exactly 1+(ROWS-1)*skew cycles, counted by a down-counter, then moves to COMMIT.
- COMMIT: assert cfg_commit for one cycle, then IDLE with done=1.
- abort in any non-IDLE state:
  - Next state is IDLE; all delay-line valid bits are cleared; cfg_shift = 0 from the next cycle.
  - No commit is issued; done = 0.
  - abort has priority over start and over beat acceptance on the same edge.
- start while busy (including in COMMIT) is ignored and pulses err for one cycle. start in IDLE with done=1 is a normal start.
- Changes to skew after start have no effect on the current pass.
- reset: state IDLE, counters 0, delay lines cleared.
  - All outputs read 0 immediately, asynchronously: cfg_out, cfg_shift, cfg_commit, busy, done, err, cfg_ready.
  - A pass interrupted by reset produces no commit.

## Timing
- Cycle n is the interval after edge n. start is sampled at edge 0, so the block is in FETCH in cycle 0.
- An accept at edge e puts the word on cfg_out row 0 with cfg_shift[0]=1 in cycle e.
- Row r shows the same word in cycle e + r*skew.
- No stalls:
  - Beat k is accepted at edge k+1.
  - DRAIN starts in cycle COLS.
  - cfg_commit is in cycle COLS+1+(ROWS-1)*skew.
  - done is high from the following cycle.
- Stalls add their length to commit latency one-for-one.
- Within a row, the words in cfg_shift cycles are exactly the accepted beats, in order, with no duplicates or drops.
- busy is high from cycle 0 through the commit cycle inclusive.
- Counter widths are $clog2(COLS+1) for the beat counter and $clog2(ROWS+1) for the drain counter.

## Test plan
- 4x4, skew=0, cfg_valid held high, row r beat k word = 0xR0K:
  - Accepts occur at edges 1-4; cfg_shift=4'b1111 in cycles 1-4 with words K=0..3.
  - cfg_commit in cycle 5; done=1 from cycle 6.
- 4x4, skew=1, same data:
  - cfg_shift[r] is high in cycles 1+r..4+r with words 0..3 in order.
  - cfg_commit in cycle 8; busy drops in cycle 9.
- 4x4, skew=0, cfg_valid low in cycles 2-3:
  - Beats are accepted at edges 1, 2, 5, 6; cfg_shift is 0 in cycles 3-4.
  - cfg_commit in cycle 7; no duplicated words.
- start pulsed in cycle 3 of a pass: err=1 in cycle 4 only; commit timing is unchanged.
- skew=1 pass with abort asserted in the first DRAIN cycle:
  - cfg_shift = 0 from the next cycle; cfg_commit is never asserted; busy=0, done=0.
  - A following start runs a full pass correctly.
- Asynchronous reset asserted mid-FETCH:
  - All outputs read 0 before the next clock edge.
  - After release, the block is IDLE, and start runs a normal pass with commit in cycle 5 (skew=0).

Source files
------------

// File: rtl/mesh_config_sequencer.sv
// mesh_config_sequencer: streams column slices of per-row configuration words
// onto the west edge of a ROWS x COLS mesh. Rows shift either aligned or skewed
// into a systolic wavefront. After the last word drains, one commit pulse
// tells the mesh to swap shadow configuration into active.
module mesh_config_sequencer #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CFG_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  skew,
    input  logic                  abort,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ROWS*CFG_W-1:0] cfg_data,
    output logic [ROWS*CFG_W-1:0] cfg_out,
    output logic [ROWS-1:0]       cfg_shift,
    output logic                  cfg_commit,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int BEAT_W  = $clog2(COLS + 1);
    localparam int DRAIN_W = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_e;

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               skew_q, skew_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    // Valid bit per delay-line stage; the timing of valid data is the same for
    // every row, only the tap position differs.
    logic [ROWS-1:0]    vld_q, vld_d;

    logic accept;
    logic shift_en;

    // Status outputs decode straight from state, so reset zeroes them at once.
    assign cfg_ready  = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign cfg_commit = (state_q == COMMIT);
    assign done       = done_q;
    assign err        = err_q;

    // abort wins over a beat arriving on the same edge.
    assign accept   = cfg_ready && cfg_valid && !abort;
    // The delay line keeps moving through stall cycles so stalls become bubbles.
    assign shift_en = ((state_q == FETCH) || (state_q == DRAIN)) && !abort;

    // Next-state, counters and status flags.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        skew_d      = skew_q;
        done_d      = done_q;
        err_d       = start && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    skew_d     = skew;
                    beat_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end
            FETCH: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_W'(COLS - 1)) begin
                        state_d     = DRAIN;
                        // Skewed rows need ROWS-1 extra cycles to empty the line.
                        drain_cnt_d = skew_q ? DRAIN_W'(ROWS - 1) : '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Cancel: back to IDLE with no commit; also blocks a same-edge start.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            skew_d  = skew_q;
        end
    end

    // Delay-line valid bits: stage 0 takes the accept, later stages follow.
    always_comb begin
        vld_d = '0;
        if (shift_en) begin
            vld_d[0] = accept;
            for (int s = 1; s < ROWS; s++) begin
                vld_d[s] = vld_q[s-1];
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            skew_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            vld_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            skew_q      <= skew_d;
            done_q      <= done_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
        end
    end

    // Per-row word stages: row r keeps stages 0..r and taps 0 or r by skew.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [CFG_W-1:0] word_q [0:r];

        // Stage registers load only with valid data, so a tap holds its last word.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // NOTE: the word stages are reset too, since cfg_out must read 0 during reset.
                for (int s = 0; s <= r; s++) begin
                    word_q[s] <= '0;
                end
            end else begin
                if (accept) begin
                    word_q[0] <= cfg_data[r*CFG_W +: CFG_W];
                end
                for (int s = 1; s <= r; s++) begin
                    if (shift_en && vld_q[s-1]) begin
                        word_q[s] <= word_q[s-1];
                    end
                end
            end
        end

        assign cfg_out[r*CFG_W +: CFG_W] = skew_q ? word_q[r] : word_q[0];
        assign cfg_shift[r]              = skew_q ? vld_q[r]  : vld_q[0];
    end

endmodule
